// File: rtl/crc_rx_arq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_rx_arq_ctrl_pkg : ARQ state encoding and default CRC polynomial  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package crc_rx_arq_ctrl_pkg;

    localparam logic [7:0] C_DEFAULT_POLY = 8'h07;

    // Explicit values keep the encoding stable for the transmit-side framer.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_DELIVER = 3'd2,
        ST_NAK     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_DROP    = 3'd5
    } arq_state_e;

endpackage
`default_nettype wire

// File: rtl/crc_rx_arq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_rx_arq_ctrl_if : frame in / payload out / status bundle          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface crc_rx_arq_ctrl_if #(
    parameter int BW     = 40,
    parameter int CRC_BW = 8,
    parameter int CNT_W  = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [BW+CRC_BW-1:0]   in_frame;
    logic                   out_valid;
    logic                   out_ready;
    logic [BW-1:0]          out_data;
    logic                   ack;
    logic                   nak;
    logic                   drop;
    logic [CNT_W-1:0]       good_cnt;
    logic [CNT_W-1:0]       bad_cnt;

    modport master (
        output in_valid, in_frame, out_ready,
        input  in_ready, out_valid, out_data, ack, nak, drop, good_cnt, bad_cnt
    );

    modport slave (
        input  in_valid, in_frame, out_ready,
        output in_ready, out_valid, out_data, ack, nak, drop, good_cnt, bad_cnt
    );
endinterface
`default_nettype wire

// File: rtl/crc_rx_arq_ctrl_crc_syndrome.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_syndrome : combinational CRC remainder of a frame, MSB first     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crc_syndrome
    import crc_rx_arq_ctrl_pkg::*;
#(
    parameter int                BW     = 40,
    parameter int                CRC_BW = 8,
    parameter logic [CRC_BW-1:0] POLY   = C_DEFAULT_POLY
) (
    input  wire logic [BW+CRC_BW-1:0] frame,
    output logic      [CRC_BW-1:0]    syndrome
);

    always_comb begin
        logic [CRC_BW-1:0] w_rem;
        logic              w_fb;
        w_rem = '0;
        w_fb  = 1'b0;
        // Zero-init serial division; a valid codeword leaves no remainder.
        for (int i = BW + CRC_BW - 1; i >= 0; i--) begin
            w_fb  = w_rem[CRC_BW-1] ^ frame[i];
            w_rem = {w_rem[CRC_BW-2:0], 1'b0};
            if (w_fb) begin
                w_rem = w_rem ^ POLY;
            end
        end
        syndrome = w_rem;
    end

endmodule
`default_nettype wire

// File: rtl/crc_rx_arq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc_rx_arq_ctrl : CRC-checked receive path with NAK/retry/drop ARQ   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module crc_rx_arq_ctrl
    import crc_rx_arq_ctrl_pkg::*;
#(
    parameter int                BW        = 40,
    parameter int                CRC_BW    = 8,
    parameter logic [CRC_BW-1:0] POLY      = C_DEFAULT_POLY,
    parameter int                MAX_RETRY = 3,
    parameter int                TIMEOUT   = 64,
    parameter int                CNT_W     = 16
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    crc_rx_arq_ctrl_if.slave   bus
);

    localparam logic [2:0] C_IDLE    = ST_IDLE;
    localparam logic [2:0] C_CHECK   = ST_CHECK;
    localparam logic [2:0] C_DELIVER = ST_DELIVER;
    localparam logic [2:0] C_NAK     = ST_NAK;
    localparam logic [2:0] C_WAIT    = ST_WAIT;
    localparam logic [2:0] C_DROP    = ST_DROP;

    localparam int             C_RW        = $clog2(MAX_RETRY + 1);
    localparam int             C_TW        = $clog2(TIMEOUT);
    localparam logic [C_RW-1:0] C_RETRY_MAX = C_RW'(MAX_RETRY);
    localparam logic [C_TW-1:0] C_TIMER_END = C_TW'(TIMEOUT - 1);

    logic [2:0]             r_state;
    logic [BW+CRC_BW-1:0]   r_frame;
    logic [C_RW-1:0]        r_retry;
    logic [C_TW-1:0]        r_timer;
    logic                   r_out_valid;
    logic [BW-1:0]          r_out_data;
    logic                   r_ack;
    logic                   r_nak;
    logic                   r_drop;
    logic [CNT_W-1:0]       r_good_cnt;
    logic [CNT_W-1:0]       r_bad_cnt;
    logic [CRC_BW-1:0]      w_syndrome;
    logic                   w_in_ready;
    logic                   w_accept;

    crc_syndrome #(
        .BW     (BW),
        .CRC_BW (CRC_BW),
        .POLY   (POLY)
    ) u_syndrome (
        .frame    (r_frame),
        .syndrome (w_syndrome)
    );

    assign w_in_ready = (r_state == C_IDLE) || (r_state == C_WAIT);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= C_IDLE;
            r_frame     <= '0;
            r_retry     <= '0;
            r_timer     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ack       <= 1'b0;
            r_nak       <= 1'b0;
            r_drop      <= 1'b0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
        end else begin
            // Pulses are raised on the edge that enters their state.
            r_ack  <= 1'b0;
            r_nak  <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                C_IDLE: begin
                    if (w_accept) begin
                        r_frame <= bus.in_frame;
                        r_state <= C_CHECK;
                    end
                end
                C_CHECK: begin
                    if (w_syndrome == '0) begin
                        r_out_data  <= r_frame[BW+CRC_BW-1:CRC_BW];
                        r_out_valid <= 1'b1;
                        r_ack       <= 1'b1;
                        r_retry     <= '0;
                        if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + 1'b1;
                        r_state     <= C_DELIVER;
                    end else begin
                        if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + 1'b1;
                        if (r_retry < C_RETRY_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_nak   <= 1'b1;
                            r_state <= C_NAK;
                        end else begin
                            r_drop  <= 1'b1;
                            r_state <= C_DROP;
                        end
                    end
                end
                C_DELIVER: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= C_IDLE;
                    end
                end
                C_NAK: begin
                    r_timer <= '0;
                    r_state <= C_WAIT;
                end
                C_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // A retransmission arriving on the timeout cycle wins.
                    if (w_accept) begin
                        r_frame <= bus.in_frame;
                        r_state <= C_CHECK;
                    end else if (r_timer == C_TIMER_END) begin
                        if (r_retry < C_RETRY_MAX) begin
                            r_retry <= r_retry + 1'b1;
                            r_nak   <= 1'b1;
                            r_state <= C_NAK;
                        end else begin
                            r_drop  <= 1'b1;
                            r_state <= C_DROP;
                        end
                    end
                end
                C_DROP: begin
                    r_retry <= '0;
                    r_state <= C_IDLE;
                end
                default: r_state <= C_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.ack       = r_ack;
    assign bus.nak       = r_nak;
    assign bus.drop      = r_drop;
    assign bus.good_cnt  = r_good_cnt;
    assign bus.bad_cnt   = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc_rx_arq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_crc_rx_arq_ctrl : directed bench for the receive ARQ controller   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_crc_rx_arq_ctrl;

    localparam int BW      = 40;
    localparam int CRC_BW  = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    // Hand-computed codewords for POLY 0x07: payload 1 -> CRC 07, 2 -> 0E, 0x100 -> 15.
    localparam logic [47:0] C_GOOD1   = 48'h0000000001_07;
    localparam logic [47:0] C_BAD1    = 48'h0000000001_06;
    localparam logic [47:0] C_GOOD2   = 48'h0000000002_0E;
    localparam logic [47:0] C_GOOD100 = 48'h0000000100_15;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;
    int   gap;

    crc_rx_arq_ctrl_if #(.BW(BW), .CRC_BW(CRC_BW), .CNT_W(CNT_W)) bus ();

    crc_rx_arq_ctrl #(
        .BW        (BW),
        .CRC_BW    (CRC_BW),
        .POLY      (8'h07),
        .MAX_RETRY (3),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_event();
        gap = 0;
        do begin
            step();
            gap++;
        end while (!(bus.nak || bus.drop) && gap < 200);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_frame  = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        rstn = 1'b1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_pulses", {bus.ack, bus.nak, bus.drop}, 0);
        chk("rst_counts", {bus.good_cnt, bus.bad_cnt}, 0);
        chk("rst_out_data", bus.out_data, 0);

        // Clean frame
        bus.in_frame = C_GOOD1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("clean_check_busy", bus.in_ready, 0);
        chk("clean_no_early_valid", bus.out_valid, 0);
        step();
        chk("clean_ack", bus.ack, 1);
        chk("clean_out_valid", bus.out_valid, 1);
        chk("clean_out_data", bus.out_data, 40'h0000000001);
        chk("clean_good", bus.good_cnt, 1);
        chk("clean_bad", bus.bad_cnt, 0);
        chk("clean_no_nak", bus.nak, 0);
        step();
        chk("clean_done_valid", bus.out_valid, 0);
        chk("clean_ack_one_cycle", bus.ack, 0);
        chk("clean_idle_ready", bus.in_ready, 1);

        // Corrupt then clean retransmission
        bus.in_frame = C_BAD1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("corrupt_nak", bus.nak, 1);
        chk("corrupt_bad", bus.bad_cnt, 1);
        chk("corrupt_no_ack", bus.ack, 0);
        step();
        chk("corrupt_nak_one_cycle", bus.nak, 0);
        chk("corrupt_wait_ready", bus.in_ready, 1);
        bus.in_frame = C_GOOD1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("retx_ack", bus.ack, 1);
        chk("retx_out_data", bus.out_data, 40'h0000000001);
        chk("retx_counts", {bus.good_cnt, bus.bad_cnt}, {16'd2, 16'd1});
        step();

        // Retry exhaustion: a fresh frame gets three NAKs before the drop
        for (int i = 0; i < 4; i++) begin
            bus.in_frame = C_BAD1;
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            step();
            if (i < 3) begin
                chk("exh_nak", bus.nak, 1);
                chk("exh_no_drop", bus.drop, 0);
            end else begin
                chk("exh_drop", bus.drop, 1);
                chk("exh_no_nak", bus.nak, 0);
            end
            chk("exh_bad", bus.bad_cnt, 64'(2 + i));
            chk("exh_no_valid", bus.out_valid, 0);
            step();
        end
        chk("exh_idle_ready", bus.in_ready, 1);
        chk("exh_drop_one_cycle", bus.drop, 0);

        // Timeout: one corrupt frame then silence
        bus.in_frame = C_BAD1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("to_first_nak", bus.nak, 1);
        for (int g = 0; g < 3; g++) begin
            wait_event();
            chk("to_gap", gap, TIMEOUT + 1);
            if (g < 2) chk("to_nak", {bus.nak, bus.drop}, 2'b10);
            else       chk("to_drop", {bus.nak, bus.drop}, 2'b01);
        end
        chk("to_bad_once", bus.bad_cnt, 6);
        step();
        chk("to_idle_ready", bus.in_ready, 1);

        // Backpressure: payload held while out_ready stays low
        bus.out_ready = 1'b0;
        bus.in_frame  = C_GOOD100;
        bus.in_valid  = 1'b1;
        step();
        bus.in_frame  = C_GOOD2;
        step();
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 40'h0000000100);
            chk("bp_ready", bus.in_ready, 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", bus.out_valid, 0);
        chk("bp_good_once", bus.good_cnt, 3);

        // Reset in the middle of WAIT
        bus.in_frame = C_BAD1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) step();
        rstn = 1'b0;
        step();
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_pulses", {bus.ack, bus.nak, bus.drop}, 0);
        chk("rst_mid_counts", {bus.good_cnt, bus.bad_cnt}, 0);
        chk("rst_mid_data", bus.out_data, 0);
        step();
        chk("rst_mid_hold_pulses", {bus.ack, bus.nak, bus.drop}, 0);
        rstn = 1'b1;
        step();
        chk("rst_mid_idle", bus.in_ready, 1);

        // Frame arriving on the very cycle the WAIT timer expires
        bus.in_frame = C_BAD1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("sim_first_nak", bus.nak, 1);
        step();
        for (int k = 0; k < TIMEOUT - 1; k++) step();
        chk("sim_still_waiting", {bus.in_ready, bus.nak}, 2'b10);
        bus.in_frame = C_GOOD2;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("sim_accepted", bus.in_ready, 0);
        chk("sim_no_extra_nak", bus.nak, 0);
        step();
        chk("sim_ack", bus.ack, 1);
        chk("sim_data", bus.out_data, 40'h0000000002);
        chk("sim_counts", {bus.good_cnt, bus.bad_cnt}, {16'd1, 16'd1});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
